// File: rtl/note_sequencer.sv
// Step sequencer that plays a note pattern from a small RAM.
// It drives the divide value and reset of a clock_divider tone generator.
module note_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned TW    = 16,
  parameter int unsigned LW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_divide,
  input  logic [LW-1:0] wr_len,
  input  logic          wr_rest,
  input  logic [TW-1:0] tick_period,
  input  logic [AW-1:0] last_step,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [N-1:0]  divide,
  output logic          div_rst,
  output logic          gate,
  output logic [AW-1:0] step,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  typedef struct packed {
    logic [N-1:0]  divide;
    logic [LW-1:0] len;
    logic          rest;
  } step_t;

  state_t        state_q, state_d;
  step_t         mem [DEPTH];
  step_t         rd_c;
  logic [TW-1:0] tc_q, tc_d, tp_q, tp_d;
  logic [LW-1:0] bc_q, bc_d, len_q, len_d;
  logic [AW-1:0] last_q, last_d, step_d;
  logic [N-1:0]  divide_d;
  logic          loop_q, loop_d, gate_d, done_d, busy_d, div_rst_d;
  logic          tick_end_c, step_end_c, more_c;

  // Pattern RAM; not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= '{divide: wr_divide, len: wr_len, rest: wr_rest};
  end

  assign rd_c       = mem[step];
  assign tick_end_c = (tc_q == tp_q);
  assign step_end_c = (state_q == PLAY) && tick_end_c && (bc_q == len_q);
  assign more_c     = (step < last_q) || loop_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      divide  <= '0;
      div_rst <= 1'b1;
      gate    <= 1'b0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tc_q    <= '0;
      bc_q    <= '0;
      len_q   <= '0;
      tp_q    <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      divide  <= divide_d;
      div_rst <= div_rst_d;
      gate    <= gate_d;
      step    <= step_d;
      busy    <= busy_d;
      done    <= done_d;
      tc_q    <= tc_d;
      bc_q    <= bc_d;
      len_q   <= len_d;
      tp_q    <= tp_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
    end
  end

  // Next-state logic; stop overrides start and step end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !stop) state_d = LOAD;
      LOAD: state_d = stop ? IDLE : PLAY;
      PLAY: begin
        if (stop)            state_d = IDLE;
        else if (step_end_c) state_d = more_c ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    divide_d  = divide;
    gate_d    = gate;
    step_d    = step;
    done_d    = 1'b0;
    tc_d      = tc_q;
    bc_d      = bc_q;
    len_d     = len_q;
    tp_d      = tp_q;
    last_d    = last_q;
    loop_d    = loop_q;
    busy_d    = (state_d != IDLE);
    div_rst_d = (state_d != PLAY);
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          tp_d   = tick_period;
          last_d = last_step;
          loop_d = loop;
          step_d = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          step_d = '0;
          gate_d = 1'b0;
        end else begin
          divide_d = rd_c.divide;
          len_d    = rd_c.len;
          gate_d   = ~rd_c.rest;
          tc_d     = '0;
          bc_d     = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          step_d = '0;
          gate_d = 1'b0;
        end else if (tick_end_c) begin
          tc_d = '0;
          bc_d = bc_q + LW'(1);
          if (bc_q == len_q) begin
            if (step < last_q) begin
              step_d = step + AW'(1);
            end else if (loop_q) begin
              step_d = '0;
            end else begin
              step_d = '0;
              gate_d = 1'b0;
              done_d = 1'b1;
            end
          end
        end else begin
          tc_d = tc_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: cycle vector table plus hand-written corner sequences.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_rest, loop, start, stop;
  logic [3:0]  wr_addr, wr_len, last_step, step;
  logic [7:0]  wr_divide, divide;
  logic [15:0] tick_period;
  logic        div_rst, gate, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_divide(wr_divide),
    .wr_len(wr_len), .wr_rest(wr_rest), .tick_period(tick_period), .last_step(last_step),
    .loop(loop), .start(start), .stop(stop), .divide(divide), .div_rst(div_rst),
    .gate(gate), .step(step), .busy(busy), .done(done)
  );

  typedef struct {
    logic        rst, start, stop, wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_div;
    logic [3:0]  wr_len;
    logic        wr_rest, lp;
    logic [15:0] exp;  // {divide, div_rst, gate, step, busy, done}
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];

  function automatic vec_t mk(input int r, s, p, w, wa, wd, wl, wrs, lp,
                              input int ed, edr, eg, es, eb, edn);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.stop = p[0]; v.wr_en = w[0];
    v.wr_addr = 4'(wa); v.wr_div = 8'(wd); v.wr_len = 4'(wl); v.wr_rest = wrs[0]; v.lp = lp[0];
    v.exp = {8'(ed), edr[0], eg[0], 4'(es), eb[0], edn[0]};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] got, e;
    int t0, found, sawdone;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_divide = '0; wr_len = '0; wr_rest = 1'b0;
    tick_period = 16'd2; last_step = 4'd1; loop = 1'b0; start = 1'b0; stop = 1'b0;

    // reset, program two steps, basic non-looping play
    repeat (2) tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,4,1,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,9,0,1,0, 0,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 0,1,0,0,1,0));
    repeat (6) tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 4,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 4,1,1,1,1,0));
    repeat (3) tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 9,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 9,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 9,1,0,0,0,0));
    // looping play with a write to step 0 during its LOAD, then rst mid-play
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1, 9,1,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,0,7,1,0,1, 4,0,1,0,1,0));
    repeat (5) tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 4,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 4,1,1,1,1,0));
    repeat (3) tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 9,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 9,1,0,0,1,0));
    repeat (6) tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 7,0,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,1,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; wr_en = tbl[i].wr_en;
      wr_addr = tbl[i].wr_addr; wr_divide = tbl[i].wr_div; wr_len = tbl[i].wr_len;
      wr_rest = tbl[i].wr_rest; loop = tbl[i].lp;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      got = {divide, div_rst, gate, step, busy, done};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL vec%0d: got %h want %h", i, got, e);
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;

    // loop period and RAM retention across rst
    tick_period = 16'd2; last_step = 4'd1; loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    chk("loop_load0", 32'({busy, div_rst, step}), 32'({1'b1, 1'b1, 4'd0}));
    tick();
    chk("ram_kept", 32'(divide), 32'd7);
    sawdone = 0;
    for (int k = 0; k < 2; k++) begin
      found = 0;
      for (int n = 0; n < 40 && found == 0; n++) begin
        tick();
        if (done) sawdone = 1;
        if (busy && div_rst && step == 4'd0) found = 1;
      end
      chk("loop_reload", found, 1);
      chk("loop_period", cyc - t0, 11);
      t0 = cyc;
    end
    chk("loop_no_done", sawdone, 0);

    // stop during PLAY of step 1
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      tick();
      if (step == 4'd1 && !div_rst) found = 1;
    end
    chk("reach_step1", found, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop", 32'({busy, gate, div_rst, step, done}), 32'({1'b0, 1'b0, 1'b1, 4'd0, 1'b0}));
    tick();
    chk("stop_no_done", 32'({busy, done}), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'({busy, div_rst}), 32'({1'b0, 1'b1}));
    tick();
    chk("start_stop_idle2", 32'(busy), 32'd0);

    // single-step pattern, one-cycle beats, start while busy ignored
    wr_en = 1'b1; wr_addr = 4'd0; wr_divide = 8'd5; wr_len = 4'd0; wr_rest = 1'b0;
    tick_period = 16'd0; last_step = 4'd0; loop = 1'b0;
    tick(); wr_en = 1'b0;
    start = 1'b1; tick();
    chk("edge_load", 32'({busy, div_rst, step}), 32'({1'b1, 1'b1, 4'd0}));
    tick(); start = 1'b0;
    chk("edge_play", 32'({divide, gate, div_rst, busy}), 32'({8'd5, 1'b1, 1'b0, 1'b1}));
    tick();
    chk("edge_done", 32'({done, busy, gate, div_rst}), 32'({1'b1, 1'b0, 1'b0, 1'b1}));
    tick();
    chk("edge_idle", 32'({done, busy}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer that configures the clock_divider tone generator: plays a programmed pattern of notes by driving the divider's divide value and reset.
- Holds each step for a programmable number of beats at a programmable tempo.
- Sits between the control/register logic and a single clock_divider instance.
- Pattern RAM writable at any time; playback is started and stopped by single-cycle pulses.

Parameters:
- N, 8, width of divide value (matches clock_divider N)
- DEPTH, 16, number of pattern steps (power of 2)
- AW, $clog2(DEPTH), step address width
- TW, 16, tempo counter width
- LW, 4, note length field width (beats minus 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  pattern RAM write strobe
- wr_addr  in  AW  step address written
- wr_divide  in  N  divide value for step
- wr_len  in  LW  step length in beats, minus 1
- wr_rest  in  1  1 = silent step
- tick_period  in  TW  cycles per beat, minus 1
- last_step  in  AW  index of final step
- loop  in  1  1 = wrap to step 0 after last_step
- start  in  1  start pulse
- stop  in  1  stop pulse
- divide  out  N  to clock_divider.divide
- div_rst  out  1  to clock_divider.rst
- gate  out  1  1 = audible note
- step  out  AW  current step index
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse, non-looping pattern finished

Behaviour:
- Reset: state IDLE; divide=0, div_rst=1, gate=0, step=0, busy=0, done=0; counters=0. Pattern RAM is not cleared by rst.
- RAM: DEPTH x (N+LW+1), synchronous write on wr_en.
  - Read during LOAD is read-before-write: a same-cycle write to the same address yields the old data.
  - Writes during playback take effect the next time that step is loaded.
- start/loop/tick_period/last_step latching: on start in IDLE, tick_period, last_step and loop are latched into internal registers. Input changes during playback are ignored.
- States:
  - IDLE: busy=0, div_rst=1, gate=0.
    - start (and not stop) -> LOAD with step=0.
    - start while busy is ignored.
  - LOAD (1 cycle): busy=1, div_rst=1.
    - Registers divide=mem[step].divide, len=mem[step].len, gate=~mem[step].rest (visible on outputs from the next cycle).
    - Clears tick counter tc and beat counter bc.
    - -> PLAY.
  - PLAY: busy=1, div_rst=0.
    - tc increments each cycle; when tc==tick_period, tc<=0 and bc increments.
    - When tc==tick_period and bc==len, the step ends:
      - step<last_step: step+1 -> LOAD
      - step==last_step and loop: step<=0 -> LOAD
      - step==last_step and not loop: -> IDLE with done=1 for one cycle, gate<=0, step<=0.
    - PLAY duration = (len+1)*(tick_period+1) cycles; total per step = that + 1 (LOAD).
- stop: in LOAD or PLAY -> IDLE next cycle with gate=0, div_rst=1, step=0, no done pulse. stop wins over a simultaneous start or step end.
- tick_period=0: one beat per cycle, legal. last_step=0: single-step pattern, legal.
- Widths: tc is TW bits, bc is LW bits; compare with ==, no overflow possible.
- rst mid-playback: immediate return to reset values; RAM contents retained.

Test Plan:
- Reset: assert rst 2 cycles -> divide=0, div_rst=1, gate=0, busy=0, done=0.
- Basic play:
  - Setup: write step0 {divide=4, len=1, rest=0} and step1 {divide=9, len=0, rest=1}; tick_period=2, last_step=1, loop=0; pulse start.
  - Required:
    - Step 0: divide=4, gate=1, div_rst=0 for 6 cycles.
    - Step 1: LOAD (div_rst=1), then divide=9, gate=0 for 3 cycles.
    - End: done pulse, busy=0.
- Loop: same pattern with loop=1 -> step sequence 0,1,0,1…; no done pulse; step period 7+4=11 cycles, measured start-of-LOAD to start-of-LOAD over two loops.
- Stop:
  - Stop during PLAY of step 1 -> next cycle busy=0, gate=0, div_rst=1, step=0, done stays 0.
  - start and stop in the same cycle from IDLE -> stays IDLE.
- Write hazard:
  - Write step0 divide=7 in the same cycle as LOAD of step0 -> old value plays.
  - Next loop iteration -> divide=7.
- Edge: tick_period=0, last_step=0, len=0, loop=0 -> LOAD, 1 PLAY cycle, done pulse; ignore start pulse issued while busy.
